// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes driving one interrupt line.
// Optional per-byte write enables are compiled in when TIMER_BYTE_ENABLE_EN is defined.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic        ctrl_byte_en;
  logic [31:0] preset_wdata;

`ifdef TIMER_BYTE_ENABLE_EN
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign ctrl_byte_en = BE[0];
  assign preset_wdata = be_merge(preset_q, Din, BE);
`else
  logic unused_be;
  assign unused_be    = ^BE;
  assign ctrl_byte_en = 1'b1;
  assign preset_wdata = Din;
`endif

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      IDLE: if (en_q) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (count_q != 32'd0) begin
          count_d = count_q - 32'd1;
        end else begin
          state_d = INT;
          flag_d  = 1'b1;
        end
      end
      INT: begin
        if (mode_q == 2'd1) begin
          flag_d  = 1'b0;
          state_d = LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus writes come last so a CTRL write overrides the FSM on the same edge.
    if (WE) begin
      case (Addr)
        ADDR_CTRL: begin
          if (ctrl_byte_en) begin
            en_d   = Din[0];
            mode_d = Din[2:1];
            im_d   = Din[3];
          end
          flag_d  = 1'b0;
          state_d = IDLE;
        end
        ADDR_PRESET: preset_d = preset_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    case (Addr)
      ADDR_CTRL:   Dout = {28'd0, im_q, mode_q, en_q};
      ADDR_PRESET: Dout = preset_q;
      ADDR_COUNT:  Dout = count_q;
      default:     Dout = 32'd0;
    endcase
  end

  assign IRQ = flag_q & im_q;

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped countdown timer on the processor's bridge bus, downstream of the CPU core. It decodes bridge writes (address word select, byte enables, write data, write enable) into three 32-bit registers. It counts down from a programmed preset and drives one hardware-interrupt line back into the core's `HWInt` inputs. It supports one-shot and auto-reload modes.

## Interface
- No parameters.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; asserted at 0.
- `Addr` input 2: word select, driven from bridge address bits [3:2].
  - 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped.
- `WE` input 1: write strobe for the selected word.
- `BE` input 4: byte enables for writes; bit i covers Din[8i+7:8i].
- `Din` input 32: write data.
- `Dout` output 32: read data for `Addr`; combinational from registers.
- `IRQ` output 1: interrupt request, wired to one `HWInt` bit.

## Operation
- **CTRL fields**
  - [0] EN: count enable.
  - [2:1] MODE: 0 = one-shot, 1 = auto-reload, 2/3 behave as 0.
  - [3] IM: interrupt mask; 1 = IRQ allowed.
  - [31:4] not stored, read 0.
- **PRESET**: 32-bit reload value, read/write.
- **COUNT**: current value, read-only; writes ignored.
- **Unmapped word (Addr 3)**: reads 0; writes ignored.
- **CTRL write side effects**: clears the internal irq flag and forces FSM to IDLE, same edge.
- **PRESET write**: takes effect at the next LOAD only; no effect on an in-progress count.
- **FSM states**: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 → LOAD; else stay.
  - LOAD: COUNT ← PRESET; → CNT.
  - CNT: EN=0 → IDLE, COUNT held. COUNT≠0 → COUNT−1. COUNT=0 → INT, flag ← 1.
  - INT, MODE≠1: EN ← 0; → IDLE; flag stays 1 until the next CTRL write.
  - INT, MODE=1: flag ← 0; → LOAD.
- **IRQ** = flag & IM.
- **Simultaneous events**
  - A CTRL write wins over any FSM update to EN, state or flag in the same cycle.
  - A PRESET write coincident with LOAD: LOAD uses the old PRESET value.
- **Arithmetic**: decrement is unsigned 32-bit and never wraps, because it only occurs when COUNT≠0.
- **PRESET=0**: LOAD → CNT with COUNT=0 → INT on the following edge.
- **Reset**: when `reset`=0, CTRL, PRESET, COUNT and flag are 0, state is IDLE, `IRQ`=0, and `Dout`=0 for every Addr.

## Timing
- Register writes land on the edge where WE=1.
- `Dout` has zero latency: it changes in the same cycle as `Addr` or register contents.
- **Enable to interrupt**: write CTRL with EN=1 at edge t.
  - Edge t+1: LOAD.
  - Edge t+2: COUNT=PRESET=N, state CNT.
  - Edge t+2+N: COUNT=0.
  - Edge t+3+N: INT; IRQ rises (if IM=1).
- **Auto-reload**: IRQ high exactly one cycle; period N+3 cycles (INT, LOAD, N+1 cycles in CNT).
- **One-shot**: IRQ stays high until a CTRL write. EN reads 0 from edge t+4+N.
- **Reset mid-count**: returns to IDLE immediately and asynchronously; IRQ drops the same instant.

## Configuration
- `TIMER_BYTE_ENABLE_EN` defined:
  - Each enabled BE byte is written.
  - BE=0 is a no-op write: CTRL side effects still apply for CTRL.
- Not defined:
  - BE is ignored and every write is full-word.
  - The `BE` port remains present but unused.

## Test plan
- **Reset**: `reset`=0 mid-count (COUNT=7) → COUNT=0, IRQ=0 and Dout=0 immediately; IDLE after release.
- **One-shot**: PRESET=5, CTRL=0x9 (EN, mode 0, IM).
  - IRQ rises after edge t+8 and stays high.
  - CTRL reads 0x8 afterwards.
  - Writing CTRL=0x8 drops IRQ next cycle.
- **Auto-reload**: PRESET=3, CTRL=0xB → IRQ one-cycle pulses every 6 cycles; COUNT sequence 3,2,1,0,0(INT),0(LOAD),3…
- **Mask and PRESET=0**
  - PRESET=0, CTRL=0x1: state reaches INT at edge t+3 but IRQ stays 0.
  - Then CTRL=0x9: flag cleared, restart, IRQ rises at t'+3.
- **Pause and ignored writes**
  - Clear EN mid-count at COUNT=4 → COUNT holds at 4.
  - COUNT write of 0x55 ignored.
  - Addr 3 reads 0.
- **Byte enables** (macro defined): PRESET=0xFFFFFFFF, then write Din=0x12345678 with BE=4'b0011 → PRESET reads 0xFFFF5678. Without the macro, PRESET reads 0x12345678.
